// File: rtl/uart_rx_if.sv
// Host-side byte handshake and error pulses of the UART receiver.
// master = uart_rx (byte producer), slave = host FIFO/register consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled start detect, 3-sample majority vote, valid/ready hold register.
// Optional parity check is compiled in with `define UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a falling edge; after a break, waits for line high first
// START  | validating the start bit at mid-window
// DATA   | shifting data bits in LSB-first
// PARITY | checking the parity bit (UART_RX_PARITY_EN only)
// STOP   | checking the stop bit, leaves half a bit early
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVS_FACTOR  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick_16x,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(OVS_FACTOR);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_S0   = CW'(OVS_FACTOR/2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(OVS_FACTOR/2);
  localparam logic [CW-1:0] C_DEC  = CW'(OVS_FACTOR/2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVS_FACTOR - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || OVS_FACTOR < 8 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0 ||
      SYNC_STAGES < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t               state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [BW-1:0]        bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic [1:0]           smp, smp_nx;
  logic                 armed, armed_nx;
  logic                 bit_maj, dec;
  logic                 do_deliver, do_ferr;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_nx, do_perr, perr_q;
`endif

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign dec     = (cnt == C_DEC);
  assign bit_maj = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    smp_nx     = smp;
    armed_nx   = armed;
    do_deliver = 1'b0;
    do_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx = par_bad;
    do_perr    = 1'b0;
`endif
    if (tick_16x) begin
      if (cnt == C_S0) smp_nx[0] = rx_s;
      if (cnt == C_S1) smp_nx[1] = rx_s;
      cnt_nx = cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt_nx = '0;
          // after a break the line must return high before a new start is accepted
          if (!armed) begin
            armed_nx = rx_s;
          end else if (!rx_s) begin
            state_nx = S_START;
            cnt_nx   = CW'(1);
          end
        end
        S_START: begin
          if (dec && bit_maj) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (cnt == C_LAST) begin
            state_nx   = S_DATA;
            bit_idx_nx = '0;
          end
        end
        S_DATA: begin
          if (dec) shreg_nx = {bit_maj, shreg[DATA_BITS-1:1]};
          if (cnt == C_LAST) begin
            if (bit_idx == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nx = S_PARITY;
`else
              state_nx = S_STOP;
`endif
            end else begin
              bit_idx_nx = bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (dec) par_bad_nx = (^shreg) ^ bit_maj ^ (PARITY_ODD != 0);
          if (cnt == C_LAST) state_nx = S_STOP;
        end
`endif
        S_STOP: begin
          if (dec) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            if (!bit_maj) begin
              do_ferr  = 1'b1;
              armed_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              do_perr = 1'b1;
`endif
            end else begin
              do_deliver = 1'b1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      smp        <= '0;
      armed      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      smp     <= smp_nx;
      armed   <= armed_nx;
      ferr_q  <= do_ferr;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_nx;
      perr_q  <= do_perr;
`endif
      // a byte accepted in the same cycle frees the slot for the new one
      if (do_deliver) begin
        if (rx_valid_q && !bus.rx_ready) begin
          ovr_q <= 1'b1;
        end else begin
          rx_data_q  <= shreg;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8 data bits, 16x oversampling, one tick every 4 clocks.
module tb_uart_rx;
  localparam int BITCLK = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_16x = 1'b0;
  logic rx = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .OVS_FACTOR(16), .SYNC_STAGES(2), .PARITY_ODD(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_16x (tick_16x),
    .rx       (rx),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick_16x = 1'b1;
      @(negedge clk);
      tick_16x = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;
  int v_cyc, n_acc, n_ferr, n_ovr, n_perr;
  logic [7:0] last_data = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  // counts outputs once per cycle, just after the inputs have settled
  always @(negedge clk) begin
    #1;
    if (bus.rx_valid === 1'b1) v_cyc++;
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
      n_acc++;
      last_data = bus.rx_data;
    end
    if (bus.frame_err === 1'b1)  n_ferr++;
    if (bus.overrun === 1'b1)    n_ovr++;
    if (bus.parity_err === 1'b1) n_perr++;
  end

  task automatic clr();
    @(negedge clk);
    v_cyc = 0; n_acc = 0; n_ferr = 0; n_ovr = 0; n_perr = 0;
    last_data = 8'h00;
  endtask

  task automatic bit_time(input logic b, input int n);
    rx = b;
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int idle_bits);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(d[i], 1);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ par_flip, 1);
`endif
    bit_time(stop_b, 1);
    if (idle_bits > 0) bit_time(1'b1, idle_bits);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", bus.rx_data); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b expected 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b expected 0", bus.overrun); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b expected 0", bus.parity_err); end
    reset = 1'b0;
    bit_time(1'b1, 2);
  endtask

  task automatic test_basic();
    clr();
    send_frame(8'h55, 1'b1, 1);
    checks++; if (v_cyc !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d expected 1", v_cyc); end
    checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL basic_data got %h expected 55", last_data); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL basic_ferr got %0d expected 0", n_ferr); end
    checks++; if (n_ovr !== 0) begin errors++; $display("FAIL basic_ovr got %0d expected 0", n_ovr); end
    checks++; if (n_perr !== 0) begin errors++; $display("FAIL basic_perr got %0d expected 0", n_perr); end
  endtask

  task automatic test_glitch();
    clr();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    bit_time(1'b1, 2);
    checks++; if (v_cyc !== 0) begin errors++; $display("FAIL glitch_valid got %0d expected 0", v_cyc); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL glitch_ferr got %0d expected 0", n_ferr); end
    send_frame(8'hC6, 1'b1, 1);
    checks++; if (last_data !== 8'hC6 || n_acc !== 1) begin errors++; $display("FAIL glitch_recover got %h/%0d expected c6/1", last_data, n_acc); end
  endtask

  task automatic test_frame_err();
    clr();
    send_frame(8'hA3, 1'b0, 1);
    checks++; if (n_ferr !== 1) begin errors++; $display("FAIL ferr_pulses got %0d expected 1", n_ferr); end
    checks++; if (v_cyc !== 0) begin errors++; $display("FAIL ferr_valid got %0d expected 0", v_cyc); end
    clr();
    send_frame(8'h0F, 1'b1, 1);
    checks++; if (last_data !== 8'h0F) begin errors++; $display("FAIL ferr_next_data got %h expected 0f", last_data); end
    checks++; if (n_acc !== 1 || n_ferr !== 0) begin errors++; $display("FAIL ferr_next_counts got acc %0d ferr %0d expected 1 0", n_acc, n_ferr); end
  endtask

  task automatic test_back_to_back();
    bus.rx_ready = 1'b0;
    clr();
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1);
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b expected 1", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h11) begin errors++; $display("FAIL b2b_held_data got %h expected 11", bus.rx_data); end
    checks++; if (n_ovr !== 1) begin errors++; $display("FAIL b2b_overrun got %0d expected 1", n_ovr); end
    bus.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b expected 0", bus.rx_valid); end
    checks++; if (n_acc !== 1 || last_data !== 8'h11) begin errors++; $display("FAIL b2b_accept got %0d/%h expected 1/11", n_acc, last_data); end
  endtask

  task automatic test_reset_midframe();
    clr();
    bit_time(1'b0, 1);
    bit_time(1'b1, 3);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    bit_time(1'b1, 8);
    checks++; if (v_cyc !== 0 || n_ferr !== 0) begin errors++; $display("FAIL midreset_out got valid %0d ferr %0d expected 0 0", v_cyc, n_ferr); end
    send_frame(8'h3C, 1'b1, 1);
    checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL midreset_data got %h expected 3c", last_data); end
    checks++; if (n_acc !== 1) begin errors++; $display("FAIL midreset_count got %0d expected 1", n_acc); end
  endtask

  task automatic test_break();
    clr();
    bit_time(1'b0, 14);
    checks++; if (n_ferr !== 1) begin errors++; $display("FAIL break_ferr got %0d expected 1", n_ferr); end
    checks++; if (v_cyc !== 0) begin errors++; $display("FAIL break_valid got %0d expected 0", v_cyc); end
    bit_time(1'b1, 2);
    send_frame(8'h5A, 1'b1, 1);
    checks++; if (last_data !== 8'h5A || n_acc !== 1) begin errors++; $display("FAIL break_recover got %h/%0d expected 5a/1", last_data, n_acc); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clr();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    checks++; if (n_perr !== 1) begin errors++; $display("FAIL parity_err got %0d expected 1", n_perr); end
    checks++; if (v_cyc !== 0) begin errors++; $display("FAIL parity_valid got %0d expected 0", v_cyc); end
    clr();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1);
    checks++; if (last_data !== 8'h07 || n_perr !== 0) begin errors++; $display("FAIL parity_ok got %h/%0d expected 07/0", last_data, n_perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
